// File: rtl/cv32e40p_lsu_pkg.sv
// cv32e40p_lsu_pkg: shared types and byte-enable lookup for the pipelined OBI load/store unit
// Exports: data_type_e, sign_ext_e, split_phase_e, lsu_resp_t (response FIFO entry), lsu_be()
package cv32e40p_lsu_pkg;
  typedef enum logic [1:0] {DT_WORD = 2'b00, DT_HALF = 2'b01, DT_BYTE = 2'b10} data_type_e;
  typedef enum logic [1:0] {SE_ZERO = 2'b00, SE_SIGN = 2'b01, SE_ONE = 2'b10} sign_ext_e;
  typedef enum logic [1:0] {PH_NONE, PH_FIRST, PH_SECOND} split_phase_e;
  typedef struct packed {
    logic         we;
    logic [1:0]   dtype;
    logic [1:0]   offset;
    logic [1:0]   sign_ext;
    split_phase_e phase;
  } lsu_resp_t;
  // dtype[1] set means byte; second beat only ever occurs for word/half
  function automatic logic [3:0] lsu_be(input logic [1:0] dtype, input logic [1:0] off, input logic second);
    if (second) return (dtype == DT_WORD) ? ~(4'b1111 << off) : 4'b0001;
    return dtype[1] ? (4'b0001 << off) : (dtype == DT_HALF) ? (4'b0011 << off) : (4'b1111 << off);
  endfunction
endpackage

// File: rtl/cv32e40p_lsu_resp_fifo.sv
// cv32e40p_lsu_resp_fifo: DEPTH-entry FIFO of per-beat response descriptors
// Ports: clk, rst_n (async, active-low), push_i/data_i, pop_i/data_o (head), full_o, empty_o, count_o
module cv32e40p_lsu_resp_fifo import cv32e40p_lsu_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  lsu_resp_t                    data_i,
  input  logic                         pop_i,
  output lsu_resp_t                    data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  lsu_resp_t     mem_q [DEPTH];
  assign data_o  = mem_q[rd_q];
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (pop_i) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/cv32e40p_lsu_obi_pipelined.sv
// cv32e40p_lsu_obi_pipelined: pipelined OBI load/store unit with internal misaligned-access splitting
// Ports: clk, rst_n (async, active-low); ex_* request from EX with ex_ready_o handshake;
//        wb_rvalid_o/wb_rdata_o/wb_err_o completion to WB; busy_o; data_* OBI master (req/gnt, rvalid)
module cv32e40p_lsu_obi_pipelined import cv32e40p_lsu_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_req_i,
  input  logic        ex_we_i,
  input  logic [1:0]  ex_type_i,
  input  logic [1:0]  ex_sign_ext_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [1:0]  ex_reg_offset_i,
  input  logic [31:0] ex_op_a_i,
  input  logic [31:0] ex_op_b_i,
  input  logic        ex_useincr_i,
  output logic        ex_ready_o,
  output logic        wb_rvalid_o,
  output logic [31:0] wb_rdata_o,
  output logic        wb_err_o,
  output logic        busy_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);
  typedef enum logic {ISSUE, SPLIT} state_e;
  state_e                     state_q, state_d;
  split_phase_e               phase;
  lsu_resp_t                  head;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic [31:0]                addr_int, rdata_q, shd, ld;
  logic [1:0]                 sh;
  logic                       misaligned, full, empty, gnt_ok, pop, err_q, fill;
  assign addr_int     = ex_useincr_i ? ex_op_a_i + ex_op_b_i : ex_op_a_i;
  assign misaligned   = (ex_type_i == DT_WORD && addr_int[1:0] != 2'b00) || (ex_type_i == DT_HALF && addr_int[1:0] == 2'b11);
  assign data_req_o   = ex_req_i & ~full;
  assign gnt_ok       = data_req_o & data_gnt_i;
  assign data_we_o    = ex_we_i;
  assign data_addr_o  = (state_q == SPLIT) ? {addr_int[31:2] + 30'd1, 2'b00} : addr_int;
  assign data_be_o    = lsu_be(ex_type_i, addr_int[1:0], state_q == SPLIT);
  assign sh           = addr_int[1:0] - ex_reg_offset_i;
  assign data_wdata_o = 32'({ex_wdata_i, ex_wdata_i} >> {sh, 3'b000});
  assign busy_o       = count != '0 || state_q == SPLIT;
  always_comb begin
    state_d    = state_q;
    ex_ready_o = 1'b0;
    phase      = PH_NONE;
    if (gnt_ok) begin
      ex_ready_o = state_q == SPLIT || !misaligned;
      phase      = (state_q == SPLIT) ? PH_SECOND : misaligned ? PH_FIRST : PH_NONE;
      state_d    = (state_q == ISSUE && misaligned) ? SPLIT : ISSUE;
    end
  end
  cv32e40p_lsu_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (gnt_ok),
    .data_i  ('{we: ex_we_i, dtype: ex_type_i, offset: addr_int[1:0], sign_ext: ex_sign_ext_i, phase: phase}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  // A stray rvalid with nothing outstanding (e.g. after reset) is dropped
  assign pop         = data_rvalid_i & ~empty;
  assign wb_rvalid_o = pop && head.phase != PH_FIRST;
  assign wb_err_o    = wb_rvalid_o & (data_err_i | (head.phase == PH_SECOND & err_q));
  // Second beat data sits above the first beat so one shift covers every split offset
  assign shd  = 32'(((head.phase == PH_SECOND) ? {data_rdata_i, rdata_q} : {32'b0, data_rdata_i}) >> {head.offset, 3'b000});
  assign fill = (head.sign_ext == SE_SIGN) ? (head.dtype[1] ? shd[7] : shd[15]) : head.sign_ext == SE_ONE;
  assign ld   = (head.dtype == DT_WORD) ? shd : head.dtype[1] ? {{24{fill}}, shd[7:0]} : {{16{fill}}, shd[15:0]};
  assign wb_rdata_o = (wb_rvalid_o && !head.we) ? ld : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ISSUE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop && head.phase == PH_FIRST) begin
        rdata_q <= data_rdata_i;
        err_q   <= data_err_i;
      end else if (wb_rvalid_o) err_q <= 1'b0;
    end
  always @(posedge clk)
    if (rst_n && data_rvalid_i) assert (!empty) else $warning("lsu: rvalid with no outstanding transaction ignored");
endmodule
